// File: rtl/rs232out_arbiter.sv
// rs232out_arbiter: shares a single rs232out transmitter between NUM_REQ
// byte producers. Each requester owns a one-byte holding register with a
// we/busy handshake. A round-robin scheduler, with optional per-message
// locking and a lock timeout, issues held bytes to the transmitter.
//
// Ports:
//   clock     - system clock, all logic on posedge
//   reset     - synchronous, active-high
//   req_data  - byte i on bits [8i+7:8i]
//   req_we    - per-requester load pulse
//   req_lock  - requester wants to keep ownership across bytes
//   req_busy  - holding register i is full
//   overrun   - sticky: req_we arrived while req_busy was high
//   grant     - one-hot current/last owner (zero after reset)
//   tx_data   - to rs232out transmit_data
//   tx_we     - to rs232out we (single-cycle pulse)
//   tx_busy   - from rs232out busy
module rs232out_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int PTR_W        = 2,
  parameter int LOCK_TIMEOUT = 1023,
  parameter int TO_W         = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_we,
  input  logic [NUM_REQ-1:0]   req_lock,
  output logic [NUM_REQ-1:0]   req_busy,
  output logic [NUM_REQ-1:0]   overrun,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic                 tx_we,
  input  logic                 tx_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

  state_t             state;
  logic [7:0]         hold [NUM_REQ];
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   lock_owner;
  logic               lock_valid;
  logic [TO_W-1:0]    to_cnt;

  logic [NUM_REQ-1:0] lock_mask;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] rot;
  logic [PTR_W-1:0]   win_idx;
  logic               win_found;
  logic               issue;
  int unsigned        cand;

  // Winner search starts one past the last issued requester and wraps.
  always_comb begin
    lock_mask = NUM_REQ'(1) << lock_owner;
    eligible  = lock_valid ? (req_busy & lock_mask) : req_busy;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    rot       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(ptr) + k) % NUM_REQ;
      rot  = eligible >> cand;
      if (!win_found && rot[0]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(cand);
      end
    end
    issue = (state == IDLE) && !tx_busy && win_found;
  end

  // Holding registers. A load into a full register is dropped and flagged;
  // the register empties on the cycle after its byte was handed over.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_busy <= '0;
      overrun  <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) hold[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req_we[i]) begin
          if (!req_busy[i]) begin
            hold[i]     <= req_data[8*i +: 8];
            req_busy[i] <= 1'b1;
          end else begin
            overrun[i] <= 1'b1;
          end
        end
        if (state == ISSUE && grant[i]) req_busy[i] <= 1'b0;
      end
    end
  end

  // Issue FSM plus lock ownership and lock timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      tx_we      <= 1'b0;
      tx_data    <= '0;
      grant      <= '0;
      ptr        <= PTR_W'(NUM_REQ - 1);
      lock_valid <= 1'b0;
      lock_owner <= '0;
      to_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            tx_data <= hold[win_idx];
            tx_we   <= 1'b1;
            grant   <= NUM_REQ'(1) << win_idx;
            ptr     <= win_idx;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          tx_we <= 1'b0;
          state <= SETTLE;
        end
        // Covers the transmitter's one-cycle lag before busy rises.
        SETTLE: begin
          tx_we <= 1'b0;
          state <= IDLE;
        end
        default: begin
          tx_we <= 1'b0;
          state <= IDLE;
        end
      endcase

      if (issue) begin
        lock_valid <= req_lock[win_idx];
        lock_owner <= win_idx;
        to_cnt     <= '0;
      end else if (lock_valid) begin
        if (!req_lock[lock_owner]) begin
          lock_valid <= 1'b0;
          to_cnt     <= '0;
        end else if (req_we[lock_owner]) begin
          to_cnt <= '0;
        end else if (LOCK_TIMEOUT != 0 && state == IDLE && !req_busy[lock_owner]) begin
          // Revoke on the cycle the count would reach LOCK_TIMEOUT.
          if (to_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
            lock_valid <= 1'b0;
            to_cnt     <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/rs232out_arbiter.md
Name: rs232out_arbiter

Overview:
- Shares one rs232out transmitter between NUM_REQ independent byte producers, e.g. the debug/trace port, the Reduceron result printer and the host-protocol responder.
- Each requester gets a one-byte holding register with a we/busy handshake in the same style as rs232out.
- A round-robin scheduler with optional message locking issues held bytes to the transmitter and respects its busy.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- PTR_W, 2: width of the round-robin pointer; must satisfy 2^PTR_W >= NUM_REQ.
- LOCK_TIMEOUT, 1023: cycles a locked owner may leave its holding register empty before the lock is revoked; 0 disables the timeout.
- TO_W, 10: width of the timeout counter; must satisfy 2^TO_W > LOCK_TIMEOUT.

Ports:
- clock, input, 1: system clock; all logic is on posedge.
- reset, input, 1: synchronous, active-high.
- req_data, input, 8*NUM_REQ: byte i is on bits [8i+7:8i].
- req_we, input, NUM_REQ: load pulse per requester.
- req_lock, input, NUM_REQ: requester asks to keep ownership across bytes.
- req_busy, output, NUM_REQ: holding register i is full.
- overrun, output, NUM_REQ: sticky flag; req_we arrived while req_busy was high.
- grant, output, NUM_REQ: one-hot current or last owner; all zero after reset.
- tx_data, output, 8: connects to rs232out transmit_data.
- tx_we, output, 1: connects to rs232out we.
- tx_busy, input, 1: connects from rs232out busy.

Behaviour:
- Reset values: req_busy=0, overrun=0, grant=0, tx_we=0, tx_data=0, state=IDLE, pointer=NUM_REQ-1 (requester 0 wins first), lock owner cleared, timeout counter=0.
- Load rules:
  - req_we[i] with req_busy[i]=0: capture req_data[i]; req_busy[i]=1 from the next cycle.
  - req_we[i] with req_busy[i]=1: byte dropped, holding register unchanged, overrun[i] set from the next cycle.
  - req_busy[i] clears in the cycle after the controller asserts tx_we for requester i.
  - Requester i may reload in that cycle; this is not an overrun.
- State machine, all outputs registered:
  - IDLE: if tx_busy=0 and the eligible set is non-empty, select a winner w. Then set tx_data=hold[w], tx_we=1, grant=onehot(w), pointer=w, and go to ISSUE.
  - ISSUE, exactly 1 cycle: tx_we=1 while in this state; go to SETTLE.
  - SETTLE, exactly 1 cycle: tx_we=0; go to IDLE. This covers the transmitter's one-cycle delay before busy rises, so stale tx_busy=0 is never sampled.
  - tx_we is therefore a single-cycle pulse.
- Latency: with tx idle, no contention and req_we in cycle t, tx_we is high in cycle t+2.
- Minimum spacing between tx_we pulses is 3 cycles. In practice spacing is set by tx_busy, about 10 bit periods.
- Eligibility and round robin:
  - If a lock owner L exists, only L is eligible.
  - Otherwise every i with req_busy[i]=1 is eligible.
  - The winner is the first eligible index searching pointer+1, pointer+2, … modulo NUM_REQ, wrapping past NUM_REQ-1 to 0.
- Lock:
  - When requester w is issued with req_lock[w]=1, w becomes lock owner.
  - The lock is released in any cycle where req_lock[L]=0.
  - Release takes effect for the next IDLE arbitration; on release, ownership passes round-robin from L.
- Timeout:
  - While a lock is held, state is IDLE and req_busy[L]=0, the counter increments each cycle; it resets whenever L loads or is issued.
  - When the count reaches LOCK_TIMEOUT, the lock is revoked and the counter is cleared.
  - L is not re-locked until it issues another byte with req_lock high.
- Simultaneous events: in one cycle, requester i may be loaded (req_we) while requester j is issued (tx_we). Both happen; there is no interaction.
- overrun[i] is cleared only by reset.
- Reset mid-transmission:
  - The controller resets, but rs232out has no reset and keeps shifting.
  - The controller waits in IDLE until tx_busy=0, so no byte is issued into a busy transmitter.
  - Bytes held at reset are lost.
- tx_we is never asserted while tx_busy=1 is sampled in IDLE.

Test Plan:
- Single byte: reset, then req_we[0] with data 0x41 at cycle t and tx idle -> tx_we=1 and tx_data=0x41 at t+2 only; req_busy[0] high t+1..t+2, low at t+3; with the real rs232out model, the serial line shows start bit, LSB-first 0x41, stop bit.
- Round robin: load 0x10,0x11,0x12,0x13 into requesters 0..3 in the same cycle -> issue order 0,1,2,3, each tx_we only after tx_busy fell. Then reload all with pointer=3 -> order 0,1,2,3 again.
- Lock: requester 2 sends 3 bytes with req_lock[2]=1 while requester 0 holds 0x55 -> all 3 bytes of requester 2 are issued before 0x55. Drop req_lock[2] -> 0x55 is issued next.
- Lock timeout with LOCK_TIMEOUT=8: requester 1 locks, then stays empty; requester 3 holds a byte -> lock revoked after 8 idle cycles and requester 3 is issued; grant changes to 0b1000.
- Overrun: req_we[2] twice in consecutive cycles (0xAA, 0xBB) -> 0xAA is transmitted, 0xBB dropped, overrun[2]=1 and held until reset.
- Reset mid-frame: assert reset 3 bit periods into a transmission while requester 1 is full -> after reset all outputs are at reset values; a new load issues only once tx_busy=0, and there is no tx_we pulse while tx_busy=1.
